// File: rtl/vixen_mem_bridge.sv
// vixen_mem_bridge: L3-to-DRAM line bridge. Turns one 512-bit line request into a
// command plus a BEATS-beat 64-bit burst and returns read lines with a one-cycle ack.
// Optional watchdog: define VIXEN_MEM_BRIDGE_TIMEOUT_EN to abort stalled transactions.
module vixen_mem_bridge #(
    parameter int unsigned BEATS   = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req,
    input  logic [63:0]           mem_addr,
    input  logic [BEATS*64-1:0]   mem_wdata,
    input  logic                  mem_we,
    output logic [BEATS*64-1:0]   mem_rdata,
    output logic                  mem_ack,
    output logic                  mem_ready,
    output logic                  bus_cmd_valid,
    input  logic                  bus_cmd_ready,
    output logic [63:0]           bus_cmd_addr,
    output logic                  bus_cmd_we,
    output logic                  bus_wvalid,
    input  logic                  bus_wready,
    output logic [63:0]           bus_wdata,
    output logic                  bus_wlast,
    input  logic                  bus_bvalid,
    input  logic                  bus_rvalid,
    output logic                  bus_rready,
    input  logic [63:0]           bus_rdata,
    input  logic                  bus_rlast,
    output logic                  err_proto,
    output logic                  err_timeout,
    output logic [31:0]           perf_reads,
    output logic [31:0]           perf_writes
);

    localparam int unsigned LineW = BEATS * 64;
    localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StWresp,
        StRdata,
        StAck
    } state_e;

    state_e             state_q, state_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [63:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [LineW-1:0]   line_q, line_d;
    logic [LineW-1:0]   rbuf_q, rbuf_d;
    logic [LineW-1:0]   rdata_q, rdata_d;
    // Set when the watchdog ended the transaction, so ACK skips the perf counters.
    logic               abort_q, abort_d;
    logic               proto_q, proto_d;
    logic [31:0]        reads_q, reads_d;
    logic [31:0]        writes_q, writes_d;

    // Registered bus/L3 outputs, decoded from the next state.
    logic               ready_q, ready_d;
    logic               ack_q, ack_d;
    logic               cmdv_q, cmdv_d;
    logic               wvalid_q, wvalid_d;
    logic               wlast_q, wlast_d;
    logic [63:0]        wdata_q, wdata_d;
    logic               rready_q, rready_d;

`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
    logic [31:0]        wdog_q, wdog_d;
    logic               tmo_q, tmo_d;
    logic               hs;
`endif

    // Line offset bits are dropped by design.
    logic unused_addr;
    assign unused_addr = ^mem_addr[5:0];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        we_d     = we_q;
        line_d   = line_q;
        rbuf_d   = rbuf_q;
        rdata_d  = rdata_q;
        abort_d  = abort_q;
        proto_d  = proto_q;
        reads_d  = reads_q;
        writes_d = writes_q;

        unique case (state_q)
            StIdle: begin
                if (mem_req) begin
                    addr_d  = {mem_addr[63:6], 6'b0};
                    we_d    = mem_we;
                    line_d  = mem_wdata;
                    beat_d  = '0;
                    abort_d = 1'b0;
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus_cmd_ready) begin
                    state_d = we_q ? StWdata : StRdata;
                end
            end
            StWdata: begin
                if (bus_wready) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StWresp;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StWresp: begin
                if (bus_bvalid) begin
                    state_d = StAck;
                end
            end
            StRdata: begin
                if (bus_rvalid) begin
                    for (int unsigned k = 0; k < BEATS; k++) begin
                        if (beat_q == BeatW'(k)) begin
                            rbuf_d[k*64 +: 64] = bus_rdata;
                        end
                    end
                    if (bus_rlast != (beat_q == LastBeat)) begin
                        proto_d = 1'b1;
                    end
                    // Completion follows the beat count, not bus_rlast.
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        rdata_d = rbuf_d;
                        state_d = StAck;
                    end else begin
                        beat_d = beat_q + BeatW'(1);
                    end
                end
            end
            StAck: begin
                if (!abort_q) begin
                    if (we_q) begin
                        writes_d = writes_q + 32'd1;
                    end else begin
                        reads_d = reads_q + 32'd1;
                    end
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
        tmo_d  = tmo_q;
        wdog_d = '0;
        hs     = 1'b0;
        unique case (state_q)
            StCmd:   hs = bus_cmd_ready;
            StWdata: hs = bus_wready;
            StWresp: hs = bus_bvalid;
            StRdata: hs = bus_rvalid;
            default: hs = 1'b0;
        endcase
        if (state_q inside {StCmd, StWdata, StWresp, StRdata} && !hs) begin
            if (wdog_q == 32'(TIMEOUT - 1)) begin
                tmo_d   = 1'b1;
                abort_d = 1'b1;
                beat_d  = '0;
                state_d = StAck;
                if (!we_q) begin
                    rdata_d = '1;
                end
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
`endif

        ready_d  = (state_d == StIdle);
        ack_d    = (state_d == StAck);
        cmdv_d   = (state_d == StCmd);
        wvalid_d = (state_d == StWdata);
        wlast_d  = wvalid_d && (beat_d == LastBeat);
        rready_d = (state_d == StRdata);
        wdata_d  = '0;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (beat_d == BeatW'(k)) begin
                wdata_d = line_d[k*64 +: 64];
            end
        end
    end

    // All state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            beat_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            line_q   <= '0;
            rbuf_q   <= '0;
            rdata_q  <= '0;
            abort_q  <= 1'b0;
            proto_q  <= 1'b0;
            reads_q  <= '0;
            writes_q <= '0;
            ready_q  <= 1'b1;
            ack_q    <= 1'b0;
            cmdv_q   <= 1'b0;
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            wdata_q  <= '0;
            rready_q <= 1'b0;
`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
            wdog_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            line_q   <= line_d;
            rbuf_q   <= rbuf_d;
            rdata_q  <= rdata_d;
            abort_q  <= abort_d;
            proto_q  <= proto_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            ready_q  <= ready_d;
            ack_q    <= ack_d;
            cmdv_q   <= cmdv_d;
            wvalid_q <= wvalid_d;
            wlast_q  <= wlast_d;
            wdata_q  <= wdata_d;
            rready_q <= rready_d;
`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
            wdog_q   <= wdog_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign mem_rdata     = rdata_q;
    assign mem_ack       = ack_q;
    assign mem_ready     = ready_q;
    assign bus_cmd_valid = cmdv_q;
    // Address and direction are only meaningful while bus_cmd_valid is high.
    assign bus_cmd_addr  = cmdv_q ? addr_q : 64'd0;
    assign bus_cmd_we    = cmdv_q & we_q;
    assign bus_wvalid    = wvalid_q;
    assign bus_wdata     = wdata_q;
    assign bus_wlast     = wlast_q;
    assign bus_rready    = rready_q;
    assign err_proto     = proto_q;
    assign perf_reads    = reads_q;
    assign perf_writes   = writes_q;
`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
    assign err_timeout   = tmo_q;
`else
    assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_vixen_mem_bridge.sv
// Self-checking bench for vixen_mem_bridge: a bus responder model checks commands and
// write beats against queued expectations, an ack monitor checks returned lines.
module tb_vixen_mem_bridge;

    localparam int unsigned BEATS = 8;
    localparam int unsigned TMO   = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mem_req;
    logic [63:0]        mem_addr;
    logic [511:0]       mem_wdata;
    logic               mem_we;
    logic [511:0]       mem_rdata;
    logic               mem_ack;
    logic               mem_ready;
    logic               bus_cmd_valid;
    logic               bus_cmd_ready;
    logic [63:0]        bus_cmd_addr;
    logic               bus_cmd_we;
    logic               bus_wvalid;
    logic               bus_wready;
    logic [63:0]        bus_wdata;
    logic               bus_wlast;
    logic               bus_bvalid;
    logic               bus_rvalid;
    logic               bus_rready;
    logic [63:0]        bus_rdata;
    logic               bus_rlast;
    logic               err_proto;
    logic               err_timeout;
    logic [31:0]        perf_reads;
    logic [31:0]        perf_writes;

    vixen_mem_bridge #(
        .BEATS   (BEATS),
        .TIMEOUT (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .mem_ready     (mem_ready),
        .bus_cmd_valid (bus_cmd_valid),
        .bus_cmd_ready (bus_cmd_ready),
        .bus_cmd_addr  (bus_cmd_addr),
        .bus_cmd_we    (bus_cmd_we),
        .bus_wvalid    (bus_wvalid),
        .bus_wready    (bus_wready),
        .bus_wdata     (bus_wdata),
        .bus_wlast     (bus_wlast),
        .bus_bvalid    (bus_bvalid),
        .bus_rvalid    (bus_rvalid),
        .bus_rready    (bus_rready),
        .bus_rdata     (bus_rdata),
        .bus_rlast     (bus_rlast),
        .err_proto     (err_proto),
        .err_timeout   (err_timeout),
        .perf_reads    (perf_reads),
        .perf_writes   (perf_writes)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Scoreboard queues.
    logic [64:0]  cmd_q[$];    // {we, addr}
    logic [64:0]  wbeat_q[$];  // {last, data}
    logic [511:0] ack_q[$];    // expected mem_rdata at each ack

    // Responder configuration and state.
    bit          cmd_block = 1'b0;
    bit          wready_alt = 1'b0;
    int          rlast_beat = 7;
    logic [63:0] rd_base = '0;
    int          rbeat = 0;
    int          wbeat = 0;
    bit          bpend = 1'b0;
    bit          wtog = 1'b1;
    int          bvalid_cyc = 0;

    int          ack_cnt = 0;
    int          ack_cyc = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired", name);
    endtask

    function automatic logic [511:0] mkline(input logic [63:0] base);
        logic [511:0] l;
        for (int k = 0; k < BEATS; k++) l[k*64 +: 64] = base + 64'(k);
        return l;
    endfunction

    // Bus responder: drives bus inputs at negedge and checks what the DUT presents.
    initial begin
        bus_cmd_ready = 1'b0;
        bus_wready    = 1'b0;
        bus_bvalid    = 1'b0;
        bus_rvalid    = 1'b0;
        bus_rdata     = '0;
        bus_rlast     = 1'b0;
        forever begin
            logic [64:0] e;
            @(negedge clk);
            if (!rst_n) begin
                rbeat = 0;
                wbeat = 0;
                bpend = 1'b0;
                bus_bvalid = 1'b0;
                bus_rvalid = 1'b0;
                bus_cmd_ready = 1'b0;
                bus_wready = 1'b0;
            end else begin
                bus_cmd_ready = !cmd_block;
                if (bus_cmd_valid && bus_cmd_ready) begin
                    if (cmd_q.size() == 0) begin
                        fail_now("cmd_unexpected");
                    end else begin
                        e = cmd_q.pop_front();
                        chk("cmd_addr", bus_cmd_addr, e[63:0]);
                        chk("cmd_we", bus_cmd_we, e[64]);
                    end
                    rbeat = 0;
                    wbeat = 0;
                end
                bus_bvalid = bpend;
                if (bpend) bvalid_cyc = cyc;
                bpend = 1'b0;
                wtog = wready_alt ? !wtog : 1'b1;
                bus_wready = wtog;
                if (bus_wvalid && bus_wready) begin
                    if (wbeat_q.size() == 0) begin
                        fail_now("wbeat_unexpected");
                    end else begin
                        e = wbeat_q.pop_front();
                        chk("wdata", bus_wdata, e[63:0]);
                        chk("wlast", bus_wlast, e[64]);
                    end
                    wbeat++;
                    if (bus_wlast) bpend = 1'b1;
                end
                bus_rvalid = bus_rready;
                bus_rdata  = rd_base + 64'(rbeat);
                bus_rlast  = (rbeat == rlast_beat);
                if (bus_rready) rbeat++;
            end
        end
    end

    // Ack monitor: pops the expected line for every completion pulse.
    initial forever begin
        logic [511:0] e;
        @(negedge clk);
        if (rst_n && mem_ack) begin
            ack_cnt++;
            ack_cyc = cyc;
            if (ack_q.size() == 0) begin
                fail_now("ack_unexpected");
            end else begin
                e = ack_q.pop_front();
                chk("ack_rdata", mem_rdata, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench stuck");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !mem_ready; i++) tick();
        if (!mem_ready) fail_now("ready_wait");
    endtask

    task automatic wait_acks(input int target, input int budget);
        for (int i = 0; i < budget && ack_cnt < target; i++) tick();
        if (ack_cnt < target) fail_now("ack_wait");
    endtask

    int req_cyc;

    task automatic issue(input logic we, input logic [63:0] addr, input logic [511:0] wd,
                         input logic [511:0] exp_rd, input bit exp_cmd);
        wait_ready(60);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wd;
        req_cyc   = cyc;
        if (exp_cmd) cmd_q.push_back({we, addr & ~64'h3F});
        if (we) begin
            for (int k = 0; k < BEATS; k++) wbeat_q.push_back({k == BEATS - 1, wd[k*64 +: 64]});
        end
        ack_q.push_back(exp_rd);
        tick();
        mem_req   = 1'b0;
        mem_wdata = '0;
    endtask

    initial begin
        logic [511:0] wd;
        logic [511:0] last_rd;
        int a0, a1, a2;
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        last_rd = '0;
        repeat (3) tick();
        chk("rst_ready", mem_ready, 1);
        chk("rst_ack", mem_ack, 0);
        chk("rst_cmdv", bus_cmd_valid, 0);
        chk("rst_wvalid", bus_wvalid, 0);
        chk("rst_rready", bus_rready, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_perf", {perf_reads, perf_writes}, 0);
        chk("rst_errs", {err_proto, err_timeout}, 0);
        rst_n = 1'b1;
        tick();

        // Zero-stall read, unaligned address.
        rd_base = 64'h0;
        last_rd = mkline(64'h0);
        issue(1'b0, 64'h1000_0047, '0, last_rd, 1'b1);
        chk("t1_cmd_lat", bus_cmd_valid, 1);
        wait_acks(1, 40);
        chk("t1_ack_lat", ack_cyc, req_cyc + 10);
        chk("t1_rd_lo", mem_rdata[63:0], 64'h0);
        chk("t1_rd_hi", mem_rdata[511:448], 64'h7);
        tick();
        chk("t1_ready_lat", mem_ready, 1);
        chk("t1_perf_reads", perf_reads, 1);

        // Write with bus_wready low on alternate cycles.
        wready_alt = 1'b1;
        for (int k = 0; k < BEATS; k++) wd[k*64 +: 64] = 64'hA0 + 64'(k);
        issue(1'b1, 64'h2000_0010, wd, last_rd, 1'b1);
        wait_acks(2, 60);
        chk("t2_ack_after_b", ack_cyc, bvalid_cyc + 1);
        tick();
        chk("t2_perf_writes", perf_writes, 1);
        chk("t2_perf_reads", perf_reads, 1);
        wready_alt = 1'b0;

        // Request held high across two transactions.
        rd_base = 64'h10;
        last_rd = mkline(64'h10);
        wait_ready(20);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h3000_0000;
        cmd_q.push_back({1'b0, 64'h3000_0000});
        cmd_q.push_back({1'b0, 64'h3000_0000});
        ack_q.push_back(last_rd);
        ack_q.push_back(last_rd);
        a0 = ack_cnt;
        wait_acks(a0 + 1, 40);
        a1 = ack_cyc;
        wait_acks(a0 + 2, 40);
        a2 = ack_cyc;
        mem_req = 1'b0;
        chk("t3_second_lat", a2, a1 + 11);
        repeat (15) tick();
        chk("t3_ack_count", ack_cnt, a0 + 2);
        chk("t3_perf_reads", perf_reads, 3);

        // bus_rlast on beat 3 instead of beat 7.
        rd_base = 64'h20;
        rlast_beat = 3;
        last_rd = mkline(64'h20);
        issue(1'b0, 64'h4000_0080, '0, last_rd, 1'b1);
        wait_acks(a0 + 3, 40);
        chk("t4_ack_lat", ack_cyc, req_cyc + 10);
        chk("t4_err_proto", err_proto, 1);
        rlast_beat = 7;
        tick();
        rd_base = 64'h30;
        last_rd = mkline(64'h30);
        issue(1'b0, 64'h4000_00C0, '0, last_rd, 1'b1);
        wait_acks(a0 + 4, 40);
        tick();
        chk("t4_err_sticky", err_proto, 1);
        chk("t4_perf_reads", perf_reads, 5);

        // Reset during write beat 4.
        issue(1'b1, 64'h2000_0100, wd, last_rd, 1'b1);
        for (int i = 0; i < 40 && wbeat < 5; i++) tick();
        if (wbeat < 5) fail_now("t5_beat_wait");
        rst_n = 1'b0;
        ack_q.delete();
        wbeat_q.delete();
        tick();
        chk("t5_valids", {bus_cmd_valid, bus_wvalid, bus_rready, mem_ack}, 0);
        chk("t5_ready", mem_ready, 1);
        chk("t5_perf", {perf_reads, perf_writes}, 0);
        chk("t5_err_proto", err_proto, 0);
        chk("t5_rdata", mem_rdata, 0);
        rst_n = 1'b1;
        tick();
        chk("t5_idle_after", {bus_cmd_valid, bus_wvalid}, 0);
        a0 = ack_cnt;
        rd_base = 64'h40;
        last_rd = mkline(64'h40);
        issue(1'b0, 64'h6000_0000, '0, last_rd, 1'b1);
        wait_acks(a0 + 1, 40);
        chk("t5_read_lat", ack_cyc, req_cyc + 10);
        tick();
        chk("t5_perf_reads", perf_reads, 1);

`ifdef VIXEN_MEM_BRIDGE_TIMEOUT_EN
        // Command never accepted: watchdog aborts.
        cmd_block = 1'b1;
        issue(1'b0, 64'h5000_0000, '0, {512{1'b1}}, 1'b0);
        chk("t6_cmd_addr", bus_cmd_addr, 64'h5000_0000);
        wait_acks(a0 + 2, 60);
        chk("t6_ack_lat", ack_cyc, req_cyc + 1 + TMO);
        tick();
        chk("t6_err_timeout", err_timeout, 1);
        chk("t6_perf_reads", perf_reads, 1);
        chk("t6_cmdv_dropped", bus_cmd_valid, 0);
        cmd_block = 1'b0;
`else
        chk("t6_no_timeout", err_timeout, 0);
`endif

        repeat (5) tick();
        chk("end_queues", cmd_q.size() + wbeat_q.size() + ack_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
